// File: rtl/menc_pkg.sv
// Shared definitions for the instruction-word format used by the encoder and the decoder.
package menc_pkg;

  // Class field: the top two bits of the instruction word.
  localparam int unsigned CLS_WIDTH = 2;

  localparam logic [CLS_WIDTH-1:0] CLS_BR  = 2'b00;
  localparam logic [CLS_WIDTH-1:0] CLS_ALU = 2'b01;
  localparam logic [CLS_WIDTH-1:0] CLS_MEM = 2'b10;
  localparam logic [CLS_WIDTH-1:0] CLS_ILL = 2'b11;

  // Branch target field starts at bit 0.
  localparam int unsigned BR_ADDR_LSB = 0;

  // Lowest bit of the class field for a given word width.
  function automatic int unsigned cls_lsb(input int unsigned instr_width);
    return instr_width - CLS_WIDTH;
  endfunction

endpackage

// File: rtl/menc_if.sv
// Upstream (class + payload) and downstream (encoded word) handshakes of the encoder.
interface menc_if #(
  parameter int unsigned INSTR_WIDTH = 32
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             in_cls;
  logic [INSTR_WIDTH-3:0] in_payload;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] out_ir;

  // Program source / decoder side.
  modport master (
    output in_valid, in_cls, in_payload, out_ready,
    input  in_ready, out_valid, out_ir
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_cls, in_payload, out_ready,
    output in_ready, out_valid, out_ir
  );

endinterface

// File: rtl/menc_fifo.sv
// Synchronous FIFO with flush; pointers carry one extra wrap bit to tell full from empty.
module menc_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en, pop_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;
  assign rdata = mem_q[rd_q[AW-1:0]];

  // Flush overrides both push and pop.
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty && !flush;

  // Next-state pointers.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_en) wr_d = wr_q + 1'b1;
      if (pop_en)  rd_d = rd_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/menc.sv
// Instruction encoder: packs class + payload into a word, rejects class 11, queues words for issue.
module menc
  import menc_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  menc_if.slave                  bus,
  output logic                   illegal,
  output logic [CNT_WIDTH-1:0]   illegal_cnt,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned CLS_LSB = cls_lsb(INSTR_WIDTH);

  logic [INSTR_WIDTH-1:0] enc;
  logic [INSTR_WIDTH-1:0] head;
  logic                   full, empty;
  logic                   xfer, push, ill_xfer;
  logic                   illegal_q;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  // in_ready is forced low while reset is held.
  assign bus.in_ready = rst_n && !full && !flush;
  assign xfer         = bus.in_valid && bus.in_ready;
  assign ill_xfer     = xfer && (bus.in_cls == CLS_ILL);
  assign push         = xfer && (bus.in_cls != CLS_ILL);

  // Word encoding; branches keep only the target field.
  always_comb begin
    enc = '0;
    unique case (bus.in_cls)
      CLS_BR: begin
        enc[CLS_LSB +: CLS_WIDTH]            = CLS_BR;
        enc[BR_ADDR_LSB +: ADDR_WIDTH]       = bus.in_payload[BR_ADDR_LSB +: ADDR_WIDTH];
      end
      CLS_ALU, CLS_MEM: begin
        enc[CLS_LSB +: CLS_WIDTH] = bus.in_cls;
        enc[CLS_LSB-1:0]          = bus.in_payload;
      end
      CLS_ILL: enc = '0;
    endcase
  end

  menc_fifo #(
    .WIDTH (INSTR_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (enc),
    .pop   (bus.out_ready),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bus.out_valid = !empty;
  assign bus.out_ir    = empty ? '0 : head;

  // Saturating count of rejected transfers.
  always_comb begin
    cnt_d = cnt_q;
    if (ill_xfer && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Illegal pulse and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      illegal_q <= ill_xfer;
      cnt_q     <= cnt_d;
    end
  end

  assign illegal     = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_menc.sv
// Scoreboard bench for menc: driver queues expected words, negedge monitor pops and compares.
module tb_menc;

  localparam int DEPTH   = 4;
  localparam int CNT_MAX = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       illegal;
  logic [1:0] illegal_cnt;
  logic [2:0] level;

  menc_if #(.INSTR_WIDTH(32)) bus ();

  menc #(
    .INSTR_WIDTH (32),
    .ADDR_WIDTH  (6),
    .DEPTH       (DEPTH),
    .CNT_WIDTH   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt),
    .level       (level)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          ill_cnt_m = 0;
  bit          ill_prev = 1'b0;
  bit          rand_rdy = 1'b0;

  // Reference encoding from the word-format rules.
  function automatic logic [31:0] model_enc(input int cls, input logic [29:0] pl);
    logic [31:0] p;
    p = 32'(pl);
    case (cls)
      0:       return p % 32'd64;
      1:       return 32'h4000_0000 + p;
      default: return 32'h8000_0000 + p;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send(input int cls, input logic [29:0] pl);
    bit ok;
    ok = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_cls     = 2'(cls);
    bus.in_payload = pl;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      if (ok && cls != 3) exp_q.push_back(model_enc(cls, pl));
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  // Random downstream backpressure.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compare DUT state to the model, pop the scoreboard on each issue.
  always @(negedge clk) begin
    if (rst_n) begin
      check("level", 32'(level), 32'(exp_q.size()));
      check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < DEPTH && !flush));
      check("illegal", 32'(illegal), 32'(ill_prev));
      check("illegal_cnt", 32'(illegal_cnt), 32'(ill_cnt_m));
      if (!bus.out_valid) check("out_ir_idle", bus.out_ir, 32'd0);
      ill_prev = bus.in_valid && bus.in_ready && (bus.in_cls == 2'b11);
      if (ill_prev && ill_cnt_m < CNT_MAX) ill_cnt_m++;
      if (flush) exp_q.delete();
      else if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", bus.out_ir, 32'hxxxx_xxxx);
        else check("out_ir", bus.out_ir, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] first_w;
    bit          drained;
    bus.in_valid   = 1'b0;
    bus.in_cls     = 2'b00;
    bus.in_payload = '0;
    bus.out_ready  = 1'b0;

    // Reset state.
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_ir", bus.out_ir, 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Branch keeps only the address field.
    send(0, 30'h3FFF_FFFF);
    @(negedge clk);
    check("br_ir", bus.out_ir, 32'h0000_003F);
    check("br_level", 32'(level), 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;

    // Back-to-back ALU / MEM with the decoder always ready.
    send(1, 30'h0000_1234);
    send(2, 30'h2000_0001);
    repeat (3) @(posedge clk);
    #1;

    // Fill with backpressure, then release; fifth word waits for a slot.
    bus.out_ready = 1'b0;
    first_w = 32'h4000_0000 + 32'(30'h0ABC_0001);
    send(1, 30'h0ABC_0001);
    for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 2)), 30'($urandom));
    @(negedge clk);
    check("full_level", 32'(level), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_hold_ir", bus.out_ir, first_w);
    @(posedge clk); #1;
    fork
      send(2, 30'h1555_AAAA);
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;

    // Illegal class: three pulses then saturation at 3.
    for (int i = 0; i < 3; i++) begin
      send(3, 30'h1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("ill_cnt3", 32'(illegal_cnt), 32'd3);
    check("ill_level", 32'(level), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) send(3, 30'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("ill_sat", 32'(illegal_cnt), 32'd3);
    @(posedge clk); #1;

    // Flush at level 3 wins over push and pop.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1, 30'($urandom));
    flush          = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_cls     = 2'b01;
    bus.out_ready  = 1'b1;
    @(posedge clk); #1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("flush_level", 32'(level), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    // Randomised traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(int'($urandom_range(0, 3)), 30'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 50 && !drained; i++) begin
      @(posedge clk);
      drained = (exp_q.size() == 0);
    end
    check("drain", 32'(drained), 32'd1);
    #1;

    // Asynchronous reset with two words pending.
    bus.out_ready = 1'b0;
    send(2, 30'h0000_0042);
    send(1, 30'h0000_0043);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_ir", bus.out_ir, 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd0);
    exp_q.delete();
    ill_cnt_m = 0;
    ill_prev  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_level", 32'(level), 32'd0);
    check("post_rst_cnt", 32'(illegal_cnt), 32'd0);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
